shift_reg_bank: RTL and testbench
=================================

Name: shift_reg_bank

Overview:
- Parametrised successor to the single-register button-load/shift block: a chain of DEPTH words, each WIDTH bits, driven by three debounced active-low push buttons.
- Load button copies sw into the most significant word; shift button moves the whole concatenated chain one bit in the current mode; mode button cycles the shift mode.
- Sits between the board buttons/switches and the LED/7-seg display logic. The display instantiates hex decoders on data_flat.

Parameters:
WIDTH, 8, bits per word (>=2)
DEPTH, 2, number of words in chain (>=1); chain length L = WIDTH*DEPTH
DEBOUNCE, 4, consecutive stable cycles required to accept a button level change (>=1)
CNT_W, 8, width of shift counter

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
btn_load  in  1  load button, active-low, asynchronous to clk
btn_shift  in  1  shift button, active-low, asynchronous
btn_mode  in  1  mode button, active-low, asynchronous
sw  in  WIDTH  load value
data_flat  out  WIDTH*DEPTH  chain contents; word DEPTH-1 is the MS slice [L-1:L-WIDTH]
mode  out  2  current shift mode
shift_out  out  1  last bit shifted/rotated out
shift_cnt  out  CNT_W  shifts since last load, saturating

Behaviour:
- Reset (reset==0 at posedge clk):
  - data_flat=0, mode=0, shift_out=0, shift_cnt=0.
  - All sync FFs and debounced levels = 1 (released); debounce counters = 0.
  - Reset overrides any press in progress; no press pulse is generated for a button held through reset release until it is released and pressed again.
- Button conditioning, per button, identical and independent:
  - 2-FF synchroniser s1 <= btn, s2 <= s1.
  - Counter cnt: if s2==db then cnt<=0. Else if cnt==DEBOUNCE-1 then db<=s2, cnt<=0. Else cnt<=cnt+1.
  - press = db_q & ~db, where db_q is db delayed one cycle. It is a one-cycle pulse on the debounced falling edge only; release generates nothing.
  - Latency: btn first sampled low at edge k -> db falls at edge k+1+DEBOUNCE -> action applied at edge k+2+DEBOUNCE.
  - A glitch shorter than DEBOUNCE cycles (after sync) produces no press.
- Actions at posedge clk when not in reset; priority load > shift:
  - load press: word DEPTH-1 <= sw. Lower words are unchanged. shift_cnt<=0. shift_out is unchanged.
  - shift press (no load press): one-bit move of the full L-bit chain D per mode:
    - 0 logical right: D<={0,D[L-1:1]}, shift_out<=D[0]
    - 1 logical left: D<={D[L-2:0],0}, shift_out<=D[L-1]
    - 2 rotate right: D<={D[0],D[L-1:1]}, shift_out<=D[0]
    - 3 arithmetic right: D<={D[L-1],D[L-1:1]}, shift_out<=D[0]
  - On each shift, shift_cnt<=shift_cnt+1, saturating at 2^CNT_W-1 (no wrap).
  - Simultaneous load and shift press: load executes; the shift press is discarded, not queued.
  - mode press: mode<=mode+1 (wraps 3->0). This is independent of load/shift. A shift in the same cycle uses the old mode.
- No other state changes. All outputs are registered; sw is sampled only on the load edge.

Test Plan:
- Reset then idle, buttons high -> data_flat=16'h0000, mode=0, shift_cnt=0, no press pulses.
- sw=8'hA5, hold btn_load low 10 cycles -> data_flat=16'hA500 exactly at edge k+6 (DEBOUNCE=4), single update, shift_cnt=0.
- From 16'hA500, mode 0, press shift 3 times -> 16'h14A0, shift_out=0, shift_cnt=3; mode 3 with 16'h8001 one press -> 16'hC000, shift_out=1.
- Mode cycling: press btn_mode 5 times -> mode=1. Then 16'h8001 mode 1 shift -> 16'h0002, shift_out=1. Mode 2 shift of 16'h0001 -> 16'h8000, shift_out=1.
- Bounce: btn_shift low 3 cycles, high 1, low 2, then high -> no shift. Pulses of 3 cycles never accepted with DEBOUNCE=4.
- Load and shift pressed on the same cycle -> only load applied, shift_cnt=0. Reset asserted mid-debounce while btn_load is held -> after reset release no load until release and re-press. Saturation with CNT_W=2: 5 shifts -> shift_cnt=3.

Source files
------------

// File: rtl/shift_reg_bank.sv
// rtl/shift_reg_bank.sv - debounced button-driven load/shift chain of DEPTH words

// rtl/shift_reg_bank.sv - button conditioner: 2-FF sync, debounce, falling-edge press pulse
module btn_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

   logic          s1;
   logic          s2;
   logic          db;
   logic          db_q;
   logic [CW-1:0] cnt;
   // v1/v2 mark when s2 holds a real post-reset sample rather than its reset value
   logic          v1;
   logic          v2;
   // armed only after the synchronised button has been seen released, so a
   // button held through reset cannot produce a press until it is re-pressed
   logic          armed;

   // synchronise, debounce and track release-after-reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         db    <= 1'b1;
         db_q  <= 1'b1;
         cnt   <= '0;
         v1    <= 1'b0;
         v2    <= 1'b0;
         armed <= 1'b0;
      end else begin
         s1   <= btn;
         s2   <= s1;
         db_q <= db;
         v1   <= 1'b1;
         v2   <= v1;
         if (v2 && s2) begin
            armed <= 1'b1;
         end
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            db  <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = db_q & ~db & armed;

endmodule

module shift_reg_bank #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 2,
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   btn_load,
   input  logic                   btn_shift,
   input  logic                   btn_mode,
   input  logic [WIDTH-1:0]       sw,
   output logic [WIDTH*DEPTH-1:0] data_flat,
   output logic [1:0]             mode,
   output logic                   shift_out,
   output logic [CNT_W-1:0]       shift_cnt
);

   localparam int L = WIDTH * DEPTH;

   localparam logic [1:0] MODE_LSR = 2'd0;
   localparam logic [1:0] MODE_LSL = 2'd1;
   localparam logic [1:0] MODE_ROR = 2'd2;
   localparam logic [1:0] MODE_ASR = 2'd3;

   logic             load_p;
   logic             shift_p;
   logic             mode_p;
   logic [L-1:0]     chain;
   logic [1:0]       mode_r;
   logic             sout_r;
   logic [CNT_W-1:0] cnt_r;

   btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_load (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_load),
      .press (load_p)
   );

   btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_shift (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_shift),
      .press (shift_p)
   );

   btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_mode (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_mode),
      .press (mode_p)
   );

   // load has priority; a coincident shift press is dropped, not queued
   always_ff @(posedge clk) begin
      if (!reset) begin
         chain  <= '0;
         sout_r <= 1'b0;
         cnt_r  <= '0;
      end else if (load_p) begin
         chain[L-1 -: WIDTH] <= sw;
         cnt_r               <= '0;
      end else if (shift_p) begin
         case (mode_r)
            MODE_LSR: begin
               chain  <= {1'b0, chain[L-1:1]};
               sout_r <= chain[0];
            end
            MODE_LSL: begin
               chain  <= {chain[L-2:0], 1'b0};
               sout_r <= chain[L-1];
            end
            MODE_ROR: begin
               chain  <= {chain[0], chain[L-1:1]};
               sout_r <= chain[0];
            end
            default: begin
               chain  <= {chain[L-1], chain[L-1:1]};
               sout_r <= chain[0];
            end
         endcase
         if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + 1'b1;
         end
      end
   end

   // mode advances independently; a same-cycle shift already used the old mode
   always_ff @(posedge clk) begin
      if (!reset) begin
         mode_r <= MODE_LSR;
      end else if (mode_p) begin
         mode_r <= mode_r + 2'd1;
      end
   end

   assign data_flat = chain;
   assign mode      = mode_r;
   assign shift_out = sout_r;
   assign shift_cnt = cnt_r;

endmodule

// File: tb/tb_shift_reg_bank.sv
// tb/tb_shift_reg_bank.sv - directed self-checking bench for shift_reg_bank
module tb_shift_reg_bank;

   logic        clk;
   logic        reset;
   logic        btn_load;
   logic        btn_shift;
   logic        btn_mode;
   logic [7:0]  sw;
   logic [15:0] data_flat;
   logic [1:0]  mode;
   logic        shift_out;
   logic [7:0]  shift_cnt;
   logic [15:0] sat_data;
   logic [1:0]  sat_mode;
   logic        sat_out;
   logic [1:0]  sat_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   shift_reg_bank #(.WIDTH(8), .DEPTH(2), .DEBOUNCE(4), .CNT_W(8)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .btn_load  (btn_load),
      .btn_shift (btn_shift),
      .btn_mode  (btn_mode),
      .sw        (sw),
      .data_flat (data_flat),
      .mode      (mode),
      .shift_out (shift_out),
      .shift_cnt (shift_cnt)
   );

   shift_reg_bank #(.WIDTH(8), .DEPTH(2), .DEBOUNCE(4), .CNT_W(2)) u_sat (
      .clk       (clk),
      .reset     (reset),
      .btn_load  (btn_load),
      .btn_shift (btn_shift),
      .btn_mode  (btn_mode),
      .sw        (sw),
      .data_flat (sat_data),
      .mode      (sat_mode),
      .shift_out (sat_out),
      .shift_cnt (sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // mask bit0 = load, bit1 = shift, bit2 = mode; hold 10 cycles then release 10
   task automatic press(input logic [2:0] mask);
      btn_load  = ~mask[0];
      btn_shift = ~mask[1];
      btn_mode  = ~mask[2];
      tick(10);
      btn_load  = 1'b1;
      btn_shift = 1'b1;
      btn_mode  = 1'b1;
      tick(10);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(5);
   endtask

   initial begin
      reset     = 1'b0;
      btn_load  = 1'b1;
      btn_shift = 1'b1;
      btn_mode  = 1'b1;
      sw        = 8'h00;
      tick(3);
      reset = 1'b1;
      tick(10);

      check("rst_data", data_flat, 16'h0000);
      check("rst_mode", mode, 2'd0);
      check("rst_cnt", shift_cnt, 8'd0);
      check("rst_sout", shift_out, 1'b0);

      // load latency: first sampled at edge k, applied at edge k+6
      sw       = 8'hA5;
      btn_load = 1'b0;
      tick(6);
      check("load_early", data_flat, 16'h0000);
      tick(1);
      check("load_edge", data_flat, 16'hA500);
      tick(3);
      btn_load = 1'b1;
      sw       = 8'h5A;
      tick(10);
      check("load_single", data_flat, 16'hA500);
      check("load_cnt", shift_cnt, 8'd0);

      // three logical right shifts
      for (int i = 0; i < 3; i++) press(3'b010);
      check("lsr3_data", data_flat, 16'h14A0);
      check("lsr3_sout", shift_out, 1'b0);
      check("lsr3_cnt", shift_cnt, 8'd3);
      check("lsr3_satcnt", sat_cnt, 2'd3);

      // bounce: low 3, high 1, low 2, then high -> no shift
      btn_shift = 1'b0; tick(3);
      btn_shift = 1'b1; tick(1);
      btn_shift = 1'b0; tick(2);
      btn_shift = 1'b1; tick(12);
      btn_shift = 1'b0; tick(3);
      btn_shift = 1'b1; tick(12);
      check("bounce_data", data_flat, 16'h14A0);
      check("bounce_cnt", shift_cnt, 8'd3);

      // mode cycling wraps: 5 presses -> 1
      for (int i = 0; i < 5; i++) press(3'b100);
      check("mode5", mode, 2'd1);
      check("mode5_data", data_flat, 16'h14A0);

      pulse_reset();
      check("rst2_data", data_flat, 16'h0000);
      check("rst2_mode", mode, 2'd0);
      check("rst2_cnt", shift_cnt, 8'd0);

      // build 0x0001 then 0x8001; lower word must survive the load
      sw = 8'h01;
      press(3'b001);
      check("ld01", data_flat, 16'h0100);
      for (int i = 0; i < 8; i++) press(3'b010);
      check("lsr8_data", data_flat, 16'h0001);
      check("lsr8_cnt", shift_cnt, 8'd8);
      check("lsr8_satcnt", sat_cnt, 2'd3);
      sw = 8'h80;
      press(3'b001);
      check("ld80", data_flat, 16'h8001);

      // mode 1 left
      press(3'b100);
      press(3'b010);
      check("lsl_data", data_flat, 16'h0002);
      check("lsl_sout", shift_out, 1'b1);

      // mode 2 rotate right
      press(3'b100);
      press(3'b010);
      check("ror1_data", data_flat, 16'h0001);
      check("ror1_sout", shift_out, 1'b0);
      press(3'b010);
      check("ror2_data", data_flat, 16'h8000);
      check("ror2_sout", shift_out, 1'b1);

      // mode 3 arithmetic right
      press(3'b100);
      check("mode3", mode, 2'd3);
      press(3'b010);
      check("asr_data", data_flat, 16'hC000);
      check("asr_sout", shift_out, 1'b0);
      check("asr_cnt", shift_cnt, 8'd4);

      // mode and shift together: shift uses old mode (asr), mode wraps to 0
      press(3'b110);
      check("modeshift_data", data_flat, 16'hE000);
      check("modeshift_mode", mode, 2'd0);
      check("modeshift_cnt", shift_cnt, 8'd5);
      check("sat5_cnt", sat_cnt, 2'd3);

      // load and shift together: only load
      sw = 8'h3C;
      press(3'b011);
      check("ldsh_data", data_flat, 16'h3C00);
      check("ldsh_cnt", shift_cnt, 8'd0);
      check("ldsh_sout", shift_out, 1'b0);

      // reset during a held load press: no load until release and re-press
      sw       = 8'hFF;
      btn_load = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(15);
      check("held_rst_data", data_flat, 16'h0000);
      btn_load = 1'b1;
      tick(10);
      check("held_rel_data", data_flat, 16'h0000);
      press(3'b001);
      check("repress_data", data_flat, 16'hFF00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
